// File: rtl/master_response_collector_pkg.sv
// Shared definitions for the master return path: default sizing and the
// slave index type used by the request decoder, arbiters and collector.
package master_response_collector_pkg;

  localparam int QTY_OF_DEVICES_DEFAULT  = 4;
  localparam int DATA_WIDTH_DEFAULT      = 32;
  localparam int MAX_OUTSTANDING_DEFAULT = 4;

  localparam int DEV_IDX_WIDTH = $clog2(QTY_OF_DEVICES_DEFAULT);

  typedef logic [DEV_IDX_WIDTH-1:0] dev_idx_t;

endpackage

// File: rtl/master_response_collector_resp_addr_fifo.sv
// resp_addr_fifo: in-order record of the slave index of each accepted
// request. The head entry names the slave whose response is awaited next.
// Occupancy is kept in a separate counter one bit wider than the pointers,
// so the pointers simply wrap.
module resp_addr_fifo
  import master_response_collector_pkg::*;
#(
  parameter int WIDTH = DEV_IDX_WIDTH,
  parameter int DEPTH = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic do_push;
  logic do_pop;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Writes into a full FIFO and reads from an empty one are dropped.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset discards every queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/master_response_collector.sv
// master_response_collector: steers slave responses back to one master in
// request order and throttles the request decoder when too many
// transactions are outstanding.
// Optional feature macro: RESP_COLLECTOR_ERR_CHECK_EN enables the sticky
// protocol-error detector; without it err is tied low.
module master_response_collector
  import master_response_collector_pkg::*;
#(
  parameter int QTY_OF_DEVICES  = QTY_OF_DEVICES_DEFAULT,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEFAULT,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 m_req,
  input  logic [$clog2(QTY_OF_DEVICES)-1:0]    m_addr,
  output logic                                 fwd_req,
  output logic                                 m_ack,
  input  logic [QTY_OF_DEVICES-1:0]            s_ack,
  input  logic [QTY_OF_DEVICES-1:0]            s_resp,
  input  logic [QTY_OF_DEVICES*DATA_WIDTH-1:0] s_rdata,
  output logic                                 m_resp,
  output logic [DATA_WIDTH-1:0]                m_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 err
);

  localparam int IDX_W = $clog2(QTY_OF_DEVICES);

  logic [IDX_W-1:0]      head;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic [DATA_WIDTH-1:0] slave_data [QTY_OF_DEVICES];

  logic                  m_resp_q, m_resp_d;
  logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;

  // Requests are held off the decoder while the FIFO is full, so an
  // accepted request always has a slot to record its slave index.
  assign fwd_req = m_req & ~full;
  assign m_ack   = fwd_req & s_ack[m_addr];

  // Only the slave at the head may complete; an entry pushed this cycle
  // is not yet visible because empty reflects registered state.
  assign pop = ~empty & s_resp[head];

  resp_addr_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_addr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (m_ack),
    .push_data (m_addr),
    .pop       (pop),
    .head_data (head),
    .full      (full),
    .empty     (empty),
    .count     (outstanding)
  );

  // Split the flat response data bus into one word per slave.
  always_comb begin
    for (int i = 0; i < QTY_OF_DEVICES; i++) begin
      slave_data[i] = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Capture the head slave's data on a pop; data holds between pops.
  always_comb begin
    m_resp_d  = pop;
    m_rdata_d = m_rdata_q;
    if (pop) begin
      m_rdata_d = slave_data[head];
    end
  end

  // Registered response towards the master.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_resp_q  <= 1'b0;
      m_rdata_q <= '0;
    end else begin
      m_resp_q  <= m_resp_d;
      m_rdata_q <= m_rdata_d;
    end
  end

  assign m_resp  = m_resp_q;
  assign m_rdata = m_rdata_q;

`ifdef RESP_COLLECTOR_ERR_CHECK_EN
  logic                      err_q, err_d;
  logic [QTY_OF_DEVICES-1:0] head_mask;

  assign head_mask = {{(QTY_OF_DEVICES-1){1'b0}}, 1'b1} << head;

  // A response from any slave other than the awaited one is a protocol
  // error; with nothing outstanding every response is unexpected.
  always_comb begin
    err_d = err_q;
    if (empty) begin
      if (|s_resp) err_d = 1'b1;
    end else begin
      if (|(s_resp & ~head_mask)) err_d = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_master_response_collector.sv
// Directed testbench for master_response_collector (4 slaves, 32-bit data,
// 4 outstanding). Expected err values follow RESP_COLLECTOR_ERR_CHECK_EN.
module tb_master_response_collector;

`ifdef RESP_COLLECTOR_ERR_CHECK_EN
  localparam logic [31:0] ERR_EXP = 32'd1;
`else
  localparam logic [31:0] ERR_EXP = 32'd0;
`endif

  logic         clk;
  logic         rst;
  logic         m_req;
  logic [1:0]   m_addr;
  logic         fwd_req;
  logic         m_ack;
  logic [3:0]   s_ack;
  logic [3:0]   s_resp;
  logic [127:0] s_rdata;
  logic         m_resp;
  logic [31:0]  m_rdata;
  logic [2:0]   outstanding;
  logic         err;

  int testsRun;
  int testsFailed;

  master_response_collector #(
    .QTY_OF_DEVICES  (4),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req       (m_req),
    .m_addr      (m_addr),
    .fwd_req     (fwd_req),
    .m_ack       (m_ack),
    .s_ack       (s_ack),
    .s_resp      (s_resp),
    .s_rdata     (s_rdata),
    .m_resp      (m_resp),
    .m_rdata     (m_rdata),
    .outstanding (outstanding),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bound on total run time so the bench always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs (just after a rising edge) and let them settle.
  task automatic applyStimulus(input logic req, input logic [1:0] addr,
                               input logic [3:0] ack, input logic [3:0] resp);
    m_req  = req;
    m_addr = addr;
    s_ack  = ack;
    s_resp = resp;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    applyStimulus(1'b0, 2'd0, 4'b0000, 4'b0000);
  endtask

  // Accept one request to the given slave.
  task automatic pushReq(input logic [1:0] addr);
    applyStimulus(1'b1, addr, 4'b0001 << addr, 4'b0000);
    tick();
  endtask

  // Pulse a response from a slave and check the registered result.
  task automatic respond(input string tag, input logic [1:0] slv,
                         input logic [31:0] expData, input logic [31:0] expOcc);
    applyStimulus(1'b0, 2'd0, 4'b0000, 4'b0001 << slv);
    tick();
    checkOutput({tag, "_resp"}, 32'(m_resp), 32'd1);
    checkOutput({tag, "_data"}, m_rdata, expData);
    checkOutput({tag, "_occ"}, 32'(outstanding), expOcc);
  endtask

  task automatic pulseReset;
    rst = 1'b1;
    #1;
    checkOutput("rst_occ", 32'(outstanding), 32'd0);
    checkOutput("rst_resp", 32'(m_resp), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst     = 1'b1;
    m_req   = 1'b0;
    m_addr  = 2'd0;
    s_ack   = 4'b0000;
    s_resp  = 4'b0000;
    s_rdata = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

    // Reset state
    tick();
    checkOutput("reset_resp", 32'(m_resp), 32'd0);
    checkOutput("reset_rdata", m_rdata, 32'd0);
    checkOutput("reset_occ", 32'(outstanding), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    idle();
    checkOutput("reset_fwd_idle", 32'(fwd_req), 32'd0);

    // Single transaction to slave 2
    applyStimulus(1'b1, 2'd2, 4'b0100, 4'b0000);
    checkOutput("single_fwd", 32'(fwd_req), 32'd1);
    checkOutput("single_ack", 32'(m_ack), 32'd1);
    tick();
    checkOutput("single_occ", 32'(outstanding), 32'd1);
    applyStimulus(1'b1, 2'd1, 4'b0100, 4'b0000);
    checkOutput("wrong_grant_ack", 32'(m_ack), 32'd0);
    idle();
    tick();
    applyStimulus(1'b0, 2'd0, 4'b0000, 4'b0100);
    checkOutput("single_pre_resp", 32'(m_resp), 32'd0);
    tick();
    checkOutput("single_resp", 32'(m_resp), 32'd1);
    checkOutput("single_data", m_rdata, 32'hA5A5_0002);
    checkOutput("single_occ0", 32'(outstanding), 32'd0);
    idle();
    tick();
    checkOutput("single_resp_drop", 32'(m_resp), 32'd0);
    checkOutput("single_err", 32'(err), 32'd0);

    // Ordering: 3,0,1 with an early response from slave 0
    pushReq(2'd3);
    pushReq(2'd0);
    pushReq(2'd1);
    checkOutput("order_occ", 32'(outstanding), 32'd3);
    applyStimulus(1'b0, 2'd0, 4'b0000, 4'b0001);
    tick();
    checkOutput("order_ignored_resp", 32'(m_resp), 32'd0);
    checkOutput("order_err", 32'(err), ERR_EXP);
    checkOutput("order_ignored_occ", 32'(outstanding), 32'd3);
    respond("order_s3", 2'd3, 32'hA5A5_0003, 32'd2);
    respond("order_s0", 2'd0, 32'hA5A5_0000, 32'd1);
    respond("order_s1", 2'd1, 32'hA5A5_0001, 32'd0);
    idle();
    tick();
    checkOutput("order_resp_drop", 32'(m_resp), 32'd0);

    // Full FIFO throttling (pushes 5..8)
    pushReq(2'd0);
    pushReq(2'd1);
    pushReq(2'd2);
    pushReq(2'd3);
    checkOutput("full_occ", 32'(outstanding), 32'd4);
    applyStimulus(1'b1, 2'd0, 4'b0001, 4'b0000);
    checkOutput("full_fwd", 32'(fwd_req), 32'd0);
    checkOutput("full_ack", 32'(m_ack), 32'd0);
    applyStimulus(1'b1, 2'd0, 4'b0001, 4'b0001);
    checkOutput("full_pop_fwd", 32'(fwd_req), 32'd0);
    tick();
    checkOutput("full_pop_resp", 32'(m_resp), 32'd1);
    checkOutput("full_pop_data", m_rdata, 32'hA5A5_0000);
    checkOutput("full_pop_occ", 32'(outstanding), 32'd3);
    applyStimulus(1'b1, 2'd0, 4'b0001, 4'b0000);
    checkOutput("full_after_fwd", 32'(fwd_req), 32'd1);
    checkOutput("full_after_ack", 32'(m_ack), 32'd1);
    tick();
    checkOutput("full_refill_occ", 32'(outstanding), 32'd4);
    respond("drain_s1", 2'd1, 32'hA5A5_0001, 32'd3);
    respond("drain_s2", 2'd2, 32'hA5A5_0002, 32'd2);
    respond("drain_s3", 2'd3, 32'hA5A5_0003, 32'd1);
    respond("drain_s0", 2'd0, 32'hA5A5_0000, 32'd0);

    // Simultaneous push/pop at occupancy 2, across the pointer wrap
    pushReq(2'd2);
    pushReq(2'd3);
    checkOutput("sim_occ", 32'(outstanding), 32'd2);
    s_rdata[95:64] = 32'h1234_5678;
    applyStimulus(1'b1, 2'd1, 4'b0010, 4'b0100);
    checkOutput("sim_ack", 32'(m_ack), 32'd1);
    tick();
    checkOutput("sim_occ_hold", 32'(outstanding), 32'd2);
    checkOutput("sim_resp", 32'(m_resp), 32'd1);
    checkOutput("sim_data", m_rdata, 32'h1234_5678);
    s_rdata[95:64] = 32'hA5A5_0002;
    applyStimulus(1'b1, 2'd0, 4'b0001, 4'b1000);
    tick();
    checkOutput("sim2_occ_hold", 32'(outstanding), 32'd2);
    checkOutput("sim2_data", m_rdata, 32'hA5A5_0003);
    respond("wrap_s1", 2'd1, 32'hA5A5_0001, 32'd1);
    respond("wrap_s0", 2'd0, 32'hA5A5_0000, 32'd0);

    // Reset with 3 outstanding, then a stray response on an empty FIFO
    pushReq(2'd1);
    pushReq(2'd2);
    pushReq(2'd3);
    idle();
    checkOutput("pre_reset_occ", 32'(outstanding), 32'd3);
    pulseReset();
    applyStimulus(1'b0, 2'd0, 4'b0000, 4'b0010);
    tick();
    checkOutput("stray_resp", 32'(m_resp), 32'd0);
    checkOutput("stray_err", 32'(err), ERR_EXP);
    checkOutput("stray_occ", 32'(outstanding), 32'd0);

    // Fresh transaction after reset completes normally
    pulseReset();
    pushReq(2'd1);
    checkOutput("fresh_occ", 32'(outstanding), 32'd1);
    respond("fresh_s1", 2'd1, 32'hA5A5_0001, 32'd0);
    idle();
    tick();
    checkOutput("fresh_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
